// File: rtl/counter_step_updown.sv
// counter_step_updown: parametrised up/down modulo counter with programmable
// wrap limit, parallel load and a registered boundary pulse.
// Optional build macro COUNTER_STEP_SAT_EN selects saturating mode; when it is
// undefined the counter wraps modulo (limit+1).
module counter_step_updown #(
  parameter int WIDTH     = 4,
  parameter int UP_STEP   = 2,
  parameter int DOWN_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH:0] C_UP   = (WIDTH+1)'(UP_STEP);
  localparam logic [WIDTH:0] C_DOWN = (WIDTH+1)'(DOWN_STEP);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH:0]   w_mod;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_deficit;
  logic [WIDTH:0]   w_tmp;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;

  assign w_cnt_x   = {1'b0, r_count};
  assign w_lim_x   = {1'b0, limit};
  assign w_mod     = w_lim_x + (WIDTH+1)'(1);
  assign w_sum     = w_cnt_x + C_UP;
  assign w_deficit = C_DOWN - w_cnt_x;

  // Next count and boundary flag for one enabled step, all in WIDTH+1 bits
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    w_tmp        = '0;
    if (up) begin
      if (w_sum <= w_lim_x) begin
        w_next_count = w_sum[WIDTH-1:0];
      end else begin
        w_next_wrap = 1'b1;
`ifdef COUNTER_STEP_SAT_EN
        w_next_count = limit;
`else
        // Wrap once; a result still above limit (step larger than the
        // modulus, or count already above limit) collapses to zero.
        w_tmp = w_sum - w_mod;
        if (w_tmp > w_lim_x) begin
          w_next_count = '0;
        end else begin
          w_next_count = w_tmp[WIDTH-1:0];
        end
`endif
      end
    end else begin
      if (w_cnt_x > w_lim_x) begin
        w_next_count = limit;
        w_next_wrap  = 1'b1;
      end else if (w_cnt_x >= C_DOWN) begin
        w_tmp        = w_cnt_x - C_DOWN;
        w_next_count = w_tmp[WIDTH-1:0];
      end else begin
        w_next_wrap = 1'b1;
`ifdef COUNTER_STEP_SAT_EN
        w_next_count = '0;
`else
        // Borrow past zero; a borrow larger than the modulus would go
        // negative, so it lands on limit instead.
        if (w_deficit > w_mod) begin
          w_next_count = limit;
        end else begin
          w_tmp        = w_mod - w_deficit;
          w_next_count = w_tmp[WIDTH-1:0];
        end
`endif
      end
    end
  end

  // Count/wrap registers: reset > load > enabled step > hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign at_limit = (r_count == limit);

endmodule

// File: tb/tb_counter_step_updown.sv
// Directed testbench for counter_step_updown (WIDTH=4, UP_STEP=2, DOWN_STEP=1).
module tb_counter_step_updown;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] limit = 4'd15;
  logic [3:0] count;
  logic       wrap;
  logic       at_limit;

  int n_cmp = 0;
  int n_err = 0;

  counter_step_updown #(.WIDTH(4), .UP_STEP(2), .DOWN_STEP(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .count    (count),
    .wrap     (wrap),
    .at_limit (at_limit)
  );

  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic rn, input logic e, input logic u,
                      input logic ld, input logic [3:0] lv);
    reset_n  = rn;
    en       = e;
    up       = u;
    load     = ld;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_c, input logic exp_w);
    n_cmp++;
    assert (count === exp_c) else begin
      n_err++;
      $error("FAIL %s count: got %0d expected %0d", tag, count, exp_c);
    end
    n_cmp++;
    assert (wrap === exp_w) else begin
      n_err++;
      $error("FAIL %s wrap: got %0b expected %0b", tag, wrap, exp_w);
    end
  endtask

  task automatic chk_lim(input string tag, input logic exp_a);
    n_cmp++;
    assert (at_limit === exp_a) else begin
      n_err++;
      $error("FAIL %s at_limit: got %0b expected %0b", tag, at_limit, exp_a);
    end
  endtask

  initial begin
    #2;
    // Reset overrides load and en, discards current value
    limit = 4'd15;
    step(1, 0, 0, 1, 4'd9);  chk("preload9", 4'd9, 0);
    step(0, 1, 1, 1, 4'd7);  chk("reset_e1", 4'd0, 0);
    step(0, 1, 1, 1, 4'd7);  chk("reset_e2", 4'd0, 0);
    chk_lim("reset_atlim", 0);
    step(1, 1, 1, 0, 4'd0);  chk("post_reset_up", 4'd2, 0);

`ifndef COUNTER_STEP_SAT_EN
    // Up through full range, wrap at 16 -> 0
    for (int unsigned v = 4; v <= 14; v += 2) begin
      step(1, 1, 1, 0, 4'd0); chk("up15_run", 4'(v), 0);
    end
    step(1, 1, 1, 0, 4'd0);  chk("up15_wrap", 4'd0, 1);

    // limit=8: 2,4,6,8 then 10-9=1
    limit = 4'd8;
    step(1, 0, 0, 1, 4'd0);  chk("load0_l8", 4'd0, 0);
    step(1, 1, 1, 0, 4'd0);  chk("up8_2", 4'd2, 0);
    step(1, 1, 1, 0, 4'd0);  chk("up8_4", 4'd4, 0);
    step(1, 1, 1, 0, 4'd0);  chk("up8_6", 4'd6, 0);
    step(1, 1, 1, 0, 4'd0);  chk("up8_8", 4'd8, 0);
    chk_lim("up8_atlim", 1);
    step(1, 1, 1, 0, 4'd0);  chk("up8_wrap", 4'd1, 1);

    // Down wrap
    limit = 4'd15;
    step(1, 0, 0, 1, 4'd0);  chk("load0_l15", 4'd0, 0);
    step(1, 1, 0, 0, 4'd0);  chk("dn15_wrap", 4'd15, 1);
    chk_lim("dn15_atlim", 1);
    step(1, 1, 0, 0, 4'd0);  chk("dn15_14", 4'd14, 0);
    limit = 4'd8;
    step(1, 0, 0, 1, 4'd0);  chk("load0_l8b", 4'd0, 0);
    step(1, 1, 0, 0, 4'd0);  chk("dn8_wrap", 4'd8, 1);
    step(1, 0, 0, 0, 4'd0);  chk("hold", 4'd8, 0);
    step(1, 0, 0, 1, 4'd1);  chk("load1", 4'd1, 0);
    step(1, 1, 0, 0, 4'd0);  chk("dn_to0", 4'd0, 0);

    // Load beats enable
    limit = 4'd15;
    step(1, 0, 0, 1, 4'd6);  chk("load6", 4'd6, 0);
    step(1, 1, 1, 1, 4'd5);  chk("load_prio", 4'd5, 0);
    step(1, 1, 1, 0, 4'd0);  chk("after_load", 4'd7, 0);

    // Limit lowered below current count
    step(1, 0, 0, 1, 4'd10); chk("load10a", 4'd10, 0);
    limit = 4'd3;
    step(1, 1, 1, 0, 4'd0);  chk("low_up", 4'd0, 1);
    step(1, 0, 0, 1, 4'd10); chk("load10b", 4'd10, 0);
    chk_lim("load10_atlim", 0);
    step(1, 1, 0, 0, 4'd0);  chk("low_dn", 4'd3, 1);
    chk_lim("low_dn_atlim", 1);

    // load_val not clipped to limit
    step(1, 0, 0, 1, 4'd12); chk("load_unclipped", 4'd12, 0);

    // limit=0: every enabled step gives 0 with wrap
    limit = 4'd0;
    step(1, 1, 1, 0, 4'd0);  chk("lim0_up", 4'd0, 1);
    step(1, 1, 0, 0, 4'd0);  chk("lim0_dn", 4'd0, 1);
    step(1, 1, 1, 0, 4'd0);  chk("lim0_up2", 4'd0, 1);
    chk_lim("lim0_atlim", 1);
`else
    // Saturating mode
    limit = 4'd15;
    step(1, 0, 0, 1, 4'd14); chk("sat_load14", 4'd14, 0);
    step(1, 1, 1, 0, 4'd0);  chk("sat_up1", 4'd15, 1);
    step(1, 1, 1, 0, 4'd0);  chk("sat_up2", 4'd15, 1);
    step(1, 0, 0, 1, 4'd0);  chk("sat_load0", 4'd0, 0);
    step(1, 1, 0, 0, 4'd0);  chk("sat_dn1", 4'd0, 1);
    step(1, 1, 0, 0, 4'd0);  chk("sat_dn2", 4'd0, 1);
    step(1, 0, 0, 1, 4'd10); chk("sat_load10", 4'd10, 0);
    limit = 4'd3;
    step(1, 1, 0, 0, 4'd0);  chk("sat_low_dn", 4'd3, 1);
    chk_lim("sat_atlim", 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
